// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared types and constants for the vending transaction sequencer
//
// Contents:
//   CREDIT_W     width of all money values (cents)
//   MEM_RD_LAT   cycles spent in LOOKUP before item memory data is sampled
//   vend_state_e transaction sequencer states
//   sat_add      16-bit add that clamps at all-ones instead of wrapping
package vend_pkg;

  localparam int CREDIT_W   = 16;
  localparam int MEM_RD_LAT = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    COLLECT  = 3'd2,
    DISPENSE = 3'd3,
    CHANGE   = 3'd4
  } vend_state_e;

  // Sum carried in CREDIT_W+1 bits; the carry out selects the clamp value.
  function automatic logic [CREDIT_W-1:0] sat_add(input logic [CREDIT_W-1:0] a,
                                                  input logic [CREDIT_W-1:0] b);
    logic [CREDIT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CREDIT_W] ? {CREDIT_W{1'b1}} : s[CREDIT_W-1:0];
  endfunction

endpackage

// File: rtl/vend_credit_acc.sv
// rtl/vend_credit_acc.sv - saturating coin credit accumulator with subtract and refund
//
// Ports:
//   clk, rst         clock, synchronous active-high reset (credit cleared, no refund)
//   add_en/add_value coin for this cycle; always folded into credit
//   sub_en/sub_value charge the item price (applied after this cycle's coin)
//   refund_en        return all credit (including this cycle's coin) and clear it
//   credit           registered credit
//   credit_with_add  credit plus this cycle's coin, saturated (for price compare)
//   refund_valid     registered one-cycle strobe, only when the refund is non-zero
//   refund_amount    amount for refund_valid, 0 otherwise
module vend_credit_acc
  import vend_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                add_en,
  input  logic [CREDIT_W-1:0] add_value,
  input  logic                sub_en,
  input  logic [CREDIT_W-1:0] sub_value,
  input  logic                refund_en,
  output logic [CREDIT_W-1:0] credit,
  output logic [CREDIT_W-1:0] credit_with_add,
  output logic                refund_valid,
  output logic [CREDIT_W-1:0] refund_amount
);

  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                refund_valid_q, refund_valid_d;
  logic [CREDIT_W-1:0] refund_amount_q, refund_amount_d;
  logic [CREDIT_W-1:0] with_coin;
  logic [CREDIT_W:0]   diff;

  always_comb begin
    with_coin       = add_en ? sat_add(credit_q, add_value) : credit_q;
    diff            = {1'b0, with_coin} - {1'b0, sub_value};
    credit_d        = with_coin;
    refund_valid_d  = 1'b0;
    refund_amount_d = '0;
    if (refund_en) begin
      credit_d        = '0;
      refund_valid_d  = (with_coin != '0);
      refund_amount_d = with_coin;
    end else if (sub_en) begin
      // Borrow means the price exceeded credit; clamp at zero rather than wrap.
      credit_d = diff[CREDIT_W] ? '0 : diff[CREDIT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q        <= '0;
      refund_valid_q  <= 1'b0;
      refund_amount_q <= '0;
    end else begin
      credit_q        <= credit_d;
      refund_valid_q  <= refund_valid_d;
      refund_amount_q <= refund_amount_d;
    end
  end

  assign credit          = credit_q;
  assign credit_with_add = with_coin;
  assign refund_valid    = refund_valid_q;
  assign refund_amount   = refund_amount_q;

endmodule

// File: rtl/vend_txn_ctrl.sv
// rtl/vend_txn_ctrl.sv - per-transaction sequencer for the vending item store
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cfg_busy                      config writer owns the memory; blocks new selections
//   sel_valid, sel_index          item selection, accepted only in IDLE
//   coin_valid, coin_value        one coin per asserted cycle, in cents
//   cancel                        user abort (IDLE and COLLECT only)
//   mem_raddr                     registered item memory read address
//   mem_item_price, mem_avail_count  item memory read data (one-cycle registered read)
//   dispense_valid, dispensed_item_index, vend_pulse  one-cycle dispense in DISPENSE
//   change_valid, change_amount   registered refund/change strobe
//   credit                        accumulated credit
//   busy                          not IDLE
//   err_sold_out                  registered pulse after a lookup found zero stock
module vend_txn_ctrl
  import vend_pkg::*;
#(
  parameter int MAX_ITEMS   = 1024,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int IW          = $clog2(MAX_ITEMS)
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_busy,
  input  logic                sel_valid,
  input  logic [IW-1:0]       sel_index,
  input  logic                coin_valid,
  input  logic [CREDIT_W-1:0] coin_value,
  input  logic                cancel,
  output logic [IW-1:0]       mem_raddr,
  input  logic [CREDIT_W-1:0] mem_item_price,
  input  logic [7:0]          mem_avail_count,
  output logic                dispense_valid,
  output logic [IW-1:0]       dispensed_item_index,
  output logic                vend_pulse,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amount,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                err_sold_out
);

  localparam int          TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [1:0]  LK_LAST = 2'(MEM_RD_LAT - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  vend_state_e         state_q, state_d;
  logic [1:0]          lk_cnt_q, lk_cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [IW-1:0]       mem_raddr_q, mem_raddr_d;
  logic [CREDIT_W-1:0] price_q, price_d;
  logic [TW-1:0]       to_cnt_q, to_cnt_d;
  logic                err_q, err_d;

  logic                sub_en, refund_en, timed_out;
  logic [CREDIT_W-1:0] credit_with_add;

  vend_credit_acc u_credit (
    .clk             (clk),
    .rst             (rst),
    .add_en          (coin_valid),
    .add_value       (coin_value),
    .sub_en          (sub_en),
    .sub_value       (price_q),
    .refund_en       (refund_en),
    .credit          (credit),
    .credit_with_add (credit_with_add),
    .refund_valid    (change_valid),
    .refund_amount   (change_amount)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lk_cnt_q    <= '0;
      idx_q       <= '0;
      mem_raddr_q <= '0;
      price_q     <= '0;
      to_cnt_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lk_cnt_q    <= lk_cnt_d;
      idx_q       <= idx_d;
      mem_raddr_q <= mem_raddr_d;
      price_q     <= price_d;
      to_cnt_q    <= to_cnt_d;
      err_q       <= err_d;
    end
  end

  // Next state and datapath controls. Coins are always added by the
  // accumulator, so no state ever drops a coin.
  always_comb begin
    state_d     = state_q;
    lk_cnt_d    = lk_cnt_q;
    idx_d       = idx_q;
    mem_raddr_d = mem_raddr_q;
    price_d     = price_q;
    to_cnt_d    = '0;
    err_d       = 1'b0;
    sub_en      = 1'b0;
    refund_en   = 1'b0;
    // A coin in the same cycle restarts the idle timer instead of expiring it.
    timed_out   = !coin_valid && (to_cnt_q == TO_LAST);

    unique case (state_q)
      IDLE: begin
        if (cancel) begin
          refund_en = 1'b1;
        end else if (sel_valid && !cfg_busy) begin
          mem_raddr_d = sel_index;
          idx_d       = sel_index;
          lk_cnt_d    = '0;
          state_d     = LOOKUP;
        end
      end
      LOOKUP: begin
        if (lk_cnt_q == LK_LAST) begin
          if (mem_avail_count == 8'd0) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            price_d = mem_item_price;
            state_d = (mem_item_price == '0) ? DISPENSE : COLLECT;
          end
        end else begin
          lk_cnt_d = lk_cnt_q + 2'd1;
        end
      end
      COLLECT: begin
        if (cancel || timed_out) begin
          refund_en = 1'b1;
          state_d   = IDLE;
        end else if (credit_with_add >= price_q) begin
          state_d = DISPENSE;
        end else if (!coin_valid) begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      DISPENSE: begin
        sub_en  = 1'b1;
        state_d = CHANGE;
      end
      CHANGE: begin
        refund_en = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dispense_valid       = (state_q == DISPENSE);
    vend_pulse           = (state_q == DISPENSE);
    dispensed_item_index = (state_q == DISPENSE) ? idx_q : '0;
    busy                 = (state_q != IDLE);
    err_sold_out         = err_q;
    mem_raddr            = mem_raddr_q;
  end

endmodule

// File: doc/vend_txn_ctrl.md
Name: vend_txn_ctrl

Overview:
- Per-transaction sequencer for the vending item store.
- Accepts a product selection and reads that item's price and stock from the item memory, which has one-cycle registered reads.
- Accumulates coin credit, then issues exactly one dispense-update pulse to the memory and reports change.
- Gates transactions while the config path is writing the memory.

Parameters:
- MAX_ITEMS, 1024, item slots in the item memory; index width IW = $clog2(MAX_ITEMS).
- TIMEOUT_CYC, 1000000, idle cycles in COLLECT before an automatic refund.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cfg_busy  in  1  config writer active; no new selection is accepted while high.
- sel_valid  in  1  selection strobe; accepted only in IDLE.
- sel_index  in  IW  selected item slot.
- coin_valid  in  1  one coin per asserted cycle.
- coin_value  in  16  coin value in cents.
- cancel  in  1  user abort.
- mem_raddr  out  IW  item memory read address (registered).
- mem_item_price  in  16  memory price output.
- mem_avail_count  in  8  memory stock output.
- dispense_valid  out  1  one-cycle stock-update pulse to the memory.
- dispensed_item_index  out  IW  slot to update; held valid with dispense_valid.
- vend_pulse  out  1  one-cycle motor drive, same cycle as dispense_valid.
- change_valid  out  1  one-cycle refund/change strobe.
- change_amount  out  16  amount for change_valid; 0 when idle.
- credit  out  16  current accumulated credit.
- busy  out  1  high in any state other than IDLE.
- err_sold_out  out  1  one-cycle pulse when the selected item has stock 0.

Behaviour:
- Reset values: state IDLE; all outputs 0, including mem_raddr, credit and the timeout counter. A reset mid-transaction discards credit with no refund strobe.
- IDLE:
  - Coins arriving here are added to credit (pre-pay is allowed).
  - sel_valid && !cfg_busy → mem_raddr <= sel_index, latch the index, go to LOOKUP.
  - sel_valid while cfg_busy is ignored.
  - cancel with credit > 0 → change_valid with change_amount = credit, credit <= 0.
- LOOKUP: fixed 2 cycles. Cycle 1 is address registered into the memory; at the end of cycle 2 the data is valid.
  - mem_avail_count == 0 → err_sold_out pulse; state goes to IDLE with credit kept.
  - Otherwise latch price; go to COLLECT.
- COLLECT:
  - Each coin_valid adds coin_value; the sum saturates at 0xFFFF.
  - Leave for DISPENSE on the first cycle in which credit (including a coin arriving that cycle) ≥ price.
  - cancel → refund all credit via change_valid, go to IDLE. Cancel takes priority over a coin in the same cycle; that coin is also refunded.
  - The timeout counter resets on each coin. At TIMEOUT_CYC it behaves as cancel.
  - Price 0 goes straight through to DISPENSE.
- DISPENSE: 1 cycle.
  - dispense_valid = vend_pulse = 1, dispensed_item_index = latched index.
  - credit <= credit − price; go to CHANGE.
  - cancel is ignored from DISPENSE onward.
- CHANGE: 1 cycle.
  - If credit > 0, change_valid = 1 with change_amount = credit; credit <= 0.
  - Go to IDLE.
- Coins in LOOKUP/DISPENSE/CHANGE are added to credit and never lost; a coin in CHANGE is included in that cycle's change.
- cfg_busy rising mid-transaction does not abort. The latched price is used even if config rewrites the slot.
- All arithmetic is 17-bit internally, saturating to 16 bits.

Decomposition:
- Package vend_pkg holds:
  - the state enum (IDLE, LOOKUP, COLLECT, DISPENSE, CHANGE);
  - CREDIT_W = 16;
  - MEM_RD_LAT = 2, as counted in LOOKUP.
- Sub-module vend_credit_acc: saturating credit accumulator with add, subtract and clear-with-refund controls.
- The FSM stays in vend_txn_ctrl.

Test Plan:
- Item 5 {price 150, count 3}; select 5; coins 100 then 50 → one dispense_valid with index 5; change_valid with 0 absent; memory count becomes 2.
- Item 7 {price 75, count 1}; coins 100 pre-paid in IDLE; select 7 → dispense 2 cycles after LOOKUP ends; change_amount = 25.
- Item 9 count 0; select 9 with credit 50 → err_sold_out pulse; no dispense; credit stays 50; cancel → change 50.
- Select 5, coin 100, then cancel and coin 25 in the same cycle → change_amount = 125, no dispense, state IDLE.
- cfg_busy = 1 with sel_valid → no LOOKUP, busy stays 0. Also: rst asserted in COLLECT with credit 60 → all outputs 0 next cycle, no change_valid.
- TIMEOUT_CYC = 10; select, coin 40, then no activity → refund 40 exactly 10 cycles after the coin. Also: coins 0xFFF0 + 0x0100 → credit saturates at 0xFFFF.
